// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the ALU family (single-cycle and iterative).
package alu_pkg;

   localparam logic [3:0] OpAdd  = 4'd0;
   localparam logic [3:0] OpSub  = 4'd1;
   localparam logic [3:0] OpAnd  = 4'd2;
   localparam logic [3:0] OpOr   = 4'd3;
   localparam logic [3:0] OpSlt  = 4'd4;
   localparam logic [3:0] OpMul  = 4'd5;
   localparam logic [3:0] OpXor  = 4'd6;
   localparam logic [3:0] OpSll  = 4'd7;
   localparam logic [3:0] OpSra  = 4'd8;
   localparam logic [3:0] OpSrl  = 4'd9;
   localparam logic [3:0] OpMulh = 4'd10;
   localparam logic [3:0] OpDiv  = 4'd11;
   localparam logic [3:0] OpDivu = 4'd12;
   localparam logic [3:0] OpRem  = 4'd13;
   localparam logic [3:0] OpRemu = 4'd14;
   localparam logic [3:0] OpSltu = 4'd15;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   function automatic logic op_is_div(input logic [3:0] op);
      return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
   endfunction

   // Opcodes whose operands are treated as two's complement and reduced to magnitudes.
   function automatic logic op_is_signed(input logic [3:0] op);
      return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative radix-2 datapath: shift-add multiply and restoring divide on magnitudes, sharing
// one adder. i_start loads operands; o_done marks the cycle whose step completes o_result.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned SHW  = $clog2(XLEN)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            i_start,
   input  logic [3:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   logic [XLEN-1:0] r_hi, r_lo, r_b;
   logic [SHW-1:0]  r_cnt;
   logic            r_busy, r_neg_q, r_neg_r;
   logic [3:0]      r_op;

   logic            w_a_neg, w_b_neg, w_div;
   logic [XLEN-1:0] w_a_mag, w_b_mag, w_hi_nxt, w_lo_nxt, w_mulh_neg;
   logic [XLEN:0]   w_sh, w_add_a, w_add_b, w_sum;

   assign w_a_neg = op_is_signed(i_op) && i_a[XLEN-1];
   assign w_b_neg = op_is_signed(i_op) && i_b[XLEN-1];
   assign w_a_mag = w_a_neg ? -i_a : i_a;
   assign w_b_mag = w_b_neg ? -i_b : i_b;

   // Divide: trial-subtract divisor from the left-shifted partial remainder.
   // Multiply: conditionally add multiplicand to the high half, then shift right.
   assign w_div   = op_is_div(r_op);
   assign w_sh    = {r_hi, r_lo[XLEN-1]};
   assign w_add_a = w_div ? w_sh : {1'b0, r_hi};
   assign w_add_b = w_div ? ~{1'b0, r_b} : (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_sum   = w_add_a + w_add_b + {{XLEN{1'b0}}, w_div};

   always_comb begin
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (w_div) begin
         w_hi_nxt = w_sum[XLEN] ? w_sh[XLEN-1:0] : w_sum[XLEN-1:0];
         w_lo_nxt = {r_lo[XLEN-2:0], ~w_sum[XLEN]};
      end else begin
         w_hi_nxt = w_sum[XLEN:1];
         w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
      end
   end

   // High half of the negated 2*XLEN product: borrow into the high half only when low is zero.
   assign w_mulh_neg = ~w_hi_nxt + {{(XLEN-1){1'b0}}, (w_lo_nxt == '0)};

   always_comb begin
      o_result = '0;
      case (r_op)
         OpMul:   o_result = w_lo_nxt;
         OpMulh:  o_result = r_neg_q ? w_mulh_neg : w_hi_nxt;
         OpDiv:   o_result = r_neg_q ? -w_lo_nxt : w_lo_nxt;
         OpDivu:  o_result = w_lo_nxt;
         OpRem:   o_result = r_neg_r ? -w_hi_nxt : w_hi_nxt;
         OpRemu:  o_result = w_hi_nxt;
         default: o_result = '0;
      endcase
   end

   assign o_done = r_busy && (r_cnt == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_op    <= OpAdd;
      end else if (i_start) begin
         r_op    <= i_op;
         r_hi    <= '0;
         r_lo    <= w_a_mag;
         r_b     <= w_b_mag;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_cnt   <= SHW'(XLEN - 1);
         r_busy  <= 1'b1;
      end else if (r_busy) begin
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle EX-stage ALU with valid/ready on both sides. Defining ALU_ITER_FAST_MUL_EN
// computes MUL/MULH with a single-cycle multiplier; divide always stays iterative.
module alu_iter
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned SHW  = $clog2(XLEN)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [XLEN-1:0] Data1_i,
   input  logic [XLEN-1:0] Data2_i,
   input  logic [3:0]      ALUSignal_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] ALUResult_o,
   output logic            DivZero_o
);

   logic [1:0]      r_state, w_state_nxt;
   logic [XLEN-1:0] r_result, w_quick, w_md_result;
   logic            r_divzero;
   logic            w_accept, w_iter, w_dz, w_md_done;
   logic [SHW-1:0]  w_shamt;

   assign ready_o     = (r_state == StIdle);
   assign valid_o     = (r_state == StDone);
   assign ALUResult_o = r_result;
   assign DivZero_o   = r_divzero;

   assign w_accept = valid_i && ready_o;
   assign w_shamt  = Data2_i[SHW-1:0];
   assign w_dz     = op_is_div(ALUSignal_i) && (Data2_i == '0);

`ifdef ALU_ITER_FAST_MUL_EN
   logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_fast_prod;

   // Sign-extended operands give the signed product; its low half also serves MUL.
   assign w_ext_a     = {{XLEN{Data1_i[XLEN-1]}}, Data1_i};
   assign w_ext_b     = {{XLEN{Data2_i[XLEN-1]}}, Data2_i};
   assign w_fast_prod = w_ext_a * w_ext_b;
   assign w_iter      = op_is_div(ALUSignal_i) && !w_dz;
`else
   assign w_iter = (op_is_div(ALUSignal_i) && !w_dz) ||
                   (ALUSignal_i == OpMul) || (ALUSignal_i == OpMulh);
`endif

   always_comb begin
      w_quick = '0;
      case (ALUSignal_i)
         OpAdd:         w_quick = Data1_i + Data2_i;
         OpSub:         w_quick = Data1_i - Data2_i;
         OpAnd:         w_quick = Data1_i & Data2_i;
         OpOr:          w_quick = Data1_i | Data2_i;
         OpXor:         w_quick = Data1_i ^ Data2_i;
         OpSlt:         w_quick = {{(XLEN-1){1'b0}}, ($signed(Data1_i) < $signed(Data2_i))};
         OpSltu:        w_quick = {{(XLEN-1){1'b0}}, (Data1_i < Data2_i)};
         OpSll:         w_quick = Data1_i << w_shamt;
         OpSra:         w_quick = $signed(Data1_i) >>> w_shamt;
         OpSrl:         w_quick = Data1_i >> w_shamt;
         // Divide/remainder only reach this path when the divisor is zero.
         OpDiv, OpDivu: w_quick = '1;
         OpRem, OpRemu: w_quick = Data1_i;
`ifdef ALU_ITER_FAST_MUL_EN
         OpMul:         w_quick = w_fast_prod[XLEN-1:0];
         OpMulh:        w_quick = w_fast_prod[2*XLEN-1:XLEN];
`endif
         default:       w_quick = '0;
      endcase
   end

   alu_iter_muldiv #(
      .XLEN (XLEN),
      .SHW  (SHW)
   ) u_muldiv (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_start  (w_accept && w_iter),
      .i_op     (ALUSignal_i),
      .i_a      (Data1_i),
      .i_b      (Data2_i),
      .o_done   (w_md_done),
      .o_result (w_md_result)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_accept) w_state_nxt = w_iter ? StCalc : StDone;
         StCalc:  if (w_md_done) w_state_nxt = StDone;
         StDone:  if (ready_i) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= StIdle;
         r_result  <= '0;
         r_divzero <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept && !w_iter) begin
            r_result  <= w_quick;
            r_divzero <= w_dz;
         end else if ((r_state == StCalc) && w_md_done) begin
            r_result  <= w_md_result;
            r_divzero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed vector table, handshake/reset sequences and
// randomized ops against an arithmetic reference model.
module tb_alu_iter;
   import alu_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] Data1_i;
   logic [31:0] Data2_i;
   logic [3:0]  ALUSignal_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] ALUResult_o;
   logic        DivZero_o;

   int n_tests = 0;
   int n_fail  = 0;

   alu_iter #(
      .XLEN (32)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .Data1_i     (Data1_i),
      .Data2_i     (Data2_i),
      .ALUSignal_i (ALUSignal_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .ALUResult_o (ALUResult_o),
      .DivZero_o   (DivZero_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        dz;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic dz);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.dz = dz;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference: {DivZero, result} from plain 32-bit arithmetic.
   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      logic        dz;
      longint      p;
      int          sh;
      logic        ovf;
      r   = '0;
      dz  = 1'b0;
      sh  = int'(b[4:0]);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OpAdd:  r = a + b;
         OpSub:  r = a - b;
         OpAnd:  r = a & b;
         OpOr:   r = a | b;
         OpXor:  r = a ^ b;
         OpSlt:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OpSltu: r = (a < b) ? 32'd1 : 32'd0;
         OpSll:  r = a << sh;
         OpSrl:  r = a >> sh;
         OpSra:  r = $signed(a) >>> sh;
         OpMul:  r = a * b;
         OpMulh: begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[63:32];
         end
         OpDiv:  begin
            if (b == 0) begin r = '1; dz = 1'b1; end
            else if (ovf) r = a;
            else r = $signed(a) / $signed(b);
         end
         OpRem:  begin
            if (b == 0) begin r = a; dz = 1'b1; end
            else if (ovf) r = '0;
            else r = $signed(a) % $signed(b);
         end
         OpDivu: begin
            if (b == 0) begin r = '1; dz = 1'b1; end
            else r = a / b;
         end
         OpRemu: begin
            if (b == 0) begin r = a; dz = 1'b1; end
            else r = a % b;
         end
         default: r = '0;
      endcase
      return {dz, r};
   endfunction

   // Edges from the accept edge (inclusive) until valid_o is seen.
   function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
      if ((op == OpDiv || op == OpDivu || op == OpRem || op == OpRemu) && b != 0) return 33;
`ifdef ALU_ITER_FAST_MUL_EN
      return 1;
`else
      if (op == OpMul || op == OpMulh) return 33;
      return 1;
`endif
   endfunction

   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic edz);
      int lat;
      int w;
      w = 0;
      while (!ready_o && w < 100) begin
         @(posedge clk_i); #1; w++;
      end
      ALUSignal_i = op; Data1_i = a; Data2_i = b; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i     = 1'b0;
      Data1_i     = $urandom;
      Data2_i     = $urandom;
      ALUSignal_i = 4'($urandom);
      lat = 1;
      while (!valid_o && lat < 100) begin
         @(posedge clk_i); #1; lat++;
      end
      check({name, " latency"}, lat, exp_lat(op, b));
      check({name, " result"}, ALUResult_o, er);
      check({name, " divzero"}, DivZero_o, edz);
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      check({name, " release"}, {ready_o, valid_o}, 2'b10);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got no end of test, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [32:0] m;
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      logic        stable, rdy_seen, seen;

      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
      Data1_i = '0; Data2_i = '0; ALUSignal_i = '0;
      #12;
      check("reset ready/valid", {ready_o, valid_o}, 2'b10);
      check("reset result", ALUResult_o, 32'h0);
      check("reset divzero", DivZero_o, 1'b0);
      #1 rst_i = 1'b0;
      @(posedge clk_i); #1;

      add_vec("add_ovf",   OpAdd,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0);
      add_vec("sltu",      OpSltu, 32'h1,         32'hFFFF_FFFF, 32'h1,         1'b0);
      add_vec("slt",       OpSlt,  32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0);
      add_vec("sub",       OpSub,  32'h0,         32'h1,          32'hFFFF_FFFF, 1'b0);
      add_vec("and",       OpAnd,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
      add_vec("or",        OpOr,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
      add_vec("xor",       OpXor,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
      add_vec("sra_mask",  OpSra,  32'h8000_0000, 32'h24,         32'hF800_0000, 1'b0);
      add_vec("sll_mask",  OpSll,  32'h1,         32'hFFFF_FFE1, 32'h2,         1'b0);
      add_vec("srl31",     OpSrl,  32'h8000_0000, 32'd31,         32'h1,         1'b0);
      add_vec("mul_m1",    OpMul,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0);
      add_vec("mulh_m1",   OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0);
      add_vec("mul_neg",   OpMul,  32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFA, 1'b0);
      add_vec("mulh_neg",  OpMulh, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 1'b0);
      add_vec("mulh_max",  OpMulh, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0);
      add_vec("div_m7_2",  OpDiv,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0);
      add_vec("rem_m7_2",  OpRem,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0);
      add_vec("div_7_m2",  OpDiv,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
      add_vec("rem_7_m2",  OpRem,  32'd7,         32'hFFFF_FFFE, 32'h1,         1'b0);
      add_vec("divu",      OpDivu, 32'd100,       32'd7,          32'd14,        1'b0);
      add_vec("remu",      OpRemu, 32'd100,       32'd7,          32'd2,         1'b0);
      add_vec("divu_z",    OpDivu, 32'd5,         32'd0,          32'hFFFF_FFFF, 1'b1);
      add_vec("remu_z",    OpRemu, 32'd5,         32'd0,          32'd5,         1'b1);
      add_vec("div_z",     OpDiv,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 1'b1);
      add_vec("rem_z",     OpRem,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 1'b1);
      add_vec("div_ovf",   OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      add_vec("rem_ovf",   OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0);

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz);
      end

      // Backpressure: result held in DONE, new request ignored until back in IDLE.
      ALUSignal_i = OpAdd; Data1_i = 32'd3; Data2_i = 32'd4; valid_i = 1'b1;
      @(posedge clk_i); #1;
      check("bp first valid", valid_o, 1'b1);
      ALUSignal_i = OpSub; Data1_i = 32'd9; Data2_i = 32'd4;
      stable = 1'b1; rdy_seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk_i); #1;
         if (ALUResult_o !== 32'd7 || valid_o !== 1'b1) stable = 1'b0;
         if (ready_o) rdy_seen = 1'b1;
      end
      check("bp result held", stable, 1'b1);
      check("bp ready low", rdy_seen, 1'b0);
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      check("bp return idle", {ready_o, valid_o}, 2'b10);
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("bp next accepted", {valid_o, ALUResult_o}, {1'b1, 32'd5});
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      ready_i = 1'b0;

      // Asynchronous reset in the middle of a divide.
      ALUSignal_i = OpDiv; Data1_i = 32'd100; Data2_i = 32'd7; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      repeat (9) @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check("rst async ready/valid", {ready_o, valid_o}, 2'b10);
      check("rst async result", ALUResult_o, 32'h0);
      #2 rst_i = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (valid_o) seen = 1'b1;
      end
      check("rst no result", seen, 1'b0);
      run_op("add_after_rst", OpAdd, 32'd20, 32'd22, 32'd42, 1'b0);

      for (int i = 0; i < 150; i++) begin
         rop = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0:       rb = 32'h0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = $urandom_range(1, 20);
            default: rb = $urandom;
         endcase
         ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         m  = ref_alu(rop, ra, rb);
         run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, m[31:0], m[32]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
